// File: rtl/bf_io_uart.sv
// bfcpu IO-port slave: '.' writes go out as 8N1 serial frames, ',' reads pop
// bytes that arrived on the serial input through a small receive FIFO.
module bf_io_uart #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd868,
  parameter int          RX_FIFO_AW   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_req,
  input  logic       io_dir,
  input  logic [7:0] io_wdata,
  output logic       io_ack,
  output logic [7:0] io_rdata,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       rx_overrun,
  output logic       rx_frame_err
);
  localparam int                    DEPTH    = 1 << RX_FIFO_AW;
  localparam logic [15:0]           LAST_CLK = CLKS_PER_BIT - 16'd1;
  localparam logic [15:0]           HALF_M1  = (CLKS_PER_BIT >> 1) - 16'd1;
  localparam logic [RX_FIFO_AW-1:0] PTR_ONE  = 1;
  localparam logic [RX_FIFO_AW:0]   CNT_ONE  = 1;

  typedef enum logic [1:0] {B_IDLE, B_WR_WAIT, B_RD_WAIT, B_ACK} bus_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  bus_state_e            bus_q;
  logic [7:0]            wdata_q;
  logic                  ack_q;
  logic [7:0]            rdata_q;

  tx_state_e             tx_q;
  logic [15:0]           tx_cnt_q;
  logic [2:0]            tx_bit_q;
  logic [7:0]            tx_shift_q;
  logic                  txd_q;

  logic                  sync1_q, sync2_q;
  rx_state_e             rx_q;
  logic [15:0]           rx_cnt_q;
  logic [2:0]            rx_bit_q;
  logic [7:0]            rx_shift_q;
  logic                  rx_prev_q;
  logic                  frame_err_q;

  logic [7:0]            fifo_mem [DEPTH];
  logic [RX_FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [RX_FIFO_AW:0]   fifo_cnt_q;
  logic                  overrun_q;

  logic tx_ready, tx_start_d, fifo_pop_d, rx_push_d, fifo_full, push_ok;

  // Accepting a write during the final stop-bit cycle makes back-to-back frames gapless.
  assign tx_ready   = (tx_q == TX_IDLE) || (tx_q == TX_STOP && tx_cnt_q == LAST_CLK);
  assign tx_start_d = (bus_q == B_WR_WAIT) && tx_ready;
  assign fifo_pop_d = (bus_q == B_RD_WAIT) && (fifo_cnt_q != '0);
  assign rx_push_d  = (rx_q == RX_STOP) && (rx_cnt_q == LAST_CLK) && sync2_q;
  assign fifo_full  = fifo_cnt_q[RX_FIFO_AW];
  assign push_ok    = rx_push_d && !fifo_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_q   <= B_IDLE;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (bus_q)
        B_IDLE: if (io_req && !ack_q) begin
          wdata_q <= io_wdata;
          bus_q   <= io_dir ? B_WR_WAIT : B_RD_WAIT;
        end
        B_WR_WAIT: if (tx_start_d) begin
          ack_q <= 1'b1;
          bus_q <= B_ACK;
        end
        B_RD_WAIT: if (fifo_pop_d) begin
          rdata_q <= fifo_mem[rd_ptr_q];
          ack_q   <= 1'b1;
          bus_q   <= B_ACK;
        end
        B_ACK: if (!io_req) begin
          ack_q <= 1'b0;
          bus_q <= B_IDLE;
        end
        default: bus_q <= B_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q       <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else if (tx_start_d) begin
      tx_q       <= TX_START;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= wdata_q;
      txd_q      <= 1'b0;
    end else begin
      case (tx_q)
        TX_IDLE: txd_q <= 1'b1;
        TX_START: if (tx_cnt_q == LAST_CLK) begin
          tx_cnt_q   <= '0;
          tx_q       <= TX_DATA;
          txd_q      <= tx_shift_q[0];
          tx_shift_q <= tx_shift_q >> 1;
        end else tx_cnt_q <= tx_cnt_q + 16'd1;
        TX_DATA: if (tx_cnt_q == LAST_CLK) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == 3'd7) begin
            tx_q  <= TX_STOP;
            txd_q <= 1'b1;
          end else begin
            tx_bit_q   <= tx_bit_q + 3'd1;
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
          end
        end else tx_cnt_q <= tx_cnt_q + 16'd1;
        TX_STOP: if (tx_cnt_q == LAST_CLK) begin
          tx_cnt_q <= '0;
          tx_q     <= TX_IDLE;
        end else tx_cnt_q <= tx_cnt_q + 16'd1;
        default: tx_q <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
    end
  end

  // Counters restart at each sample point, so every later sample lands mid-bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q        <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_prev_q   <= 1'b1;
      frame_err_q <= 1'b0;
    end else begin
      rx_prev_q <= sync2_q;
      case (rx_q)
        RX_IDLE: if (rx_prev_q && !sync2_q) begin
          rx_q     <= RX_START;
          rx_cnt_q <= '0;
        end
        RX_START: if (rx_cnt_q == HALF_M1) begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          rx_q     <= sync2_q ? RX_IDLE : RX_DATA;
        end else rx_cnt_q <= rx_cnt_q + 16'd1;
        RX_DATA: if (rx_cnt_q == LAST_CLK) begin
          rx_cnt_q   <= '0;
          rx_shift_q <= {sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_q <= RX_STOP;
          else rx_bit_q <= rx_bit_q + 3'd1;
        end else rx_cnt_q <= rx_cnt_q + 16'd1;
        RX_STOP: if (rx_cnt_q == LAST_CLK) begin
          rx_cnt_q <= '0;
          rx_q     <= RX_IDLE;
          if (!sync2_q) frame_err_q <= 1'b1;
        end else rx_cnt_q <= rx_cnt_q + 16'd1;
        default: rx_q <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= rx_shift_q;
  end

  // A pop is only offered when the count was already non-zero, so push+pop on empty defers the pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      if (push_ok)              wr_ptr_q  <= wr_ptr_q + PTR_ONE;
      if (fifo_pop_d)           rd_ptr_q  <= rd_ptr_q + PTR_ONE;
      if (rx_push_d && fifo_full) overrun_q <= 1'b1;
      case ({push_ok, fifo_pop_d})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_ONE;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_ONE;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign io_ack       = ack_q;
  assign io_rdata     = rdata_q;
  assign uart_txd     = txd_q;
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = frame_err_q;

endmodule

// File: tb/tb_bf_io_uart.sv
// Self-checking bench for bf_io_uart: behavioural frame/FIFO model, per-cycle
// serial-output compare, directed cases followed by randomized traffic.
`timescale 1ns/1ps
module tb_bf_io_uart;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       io_req = 1'b0;
  logic       io_dir = 1'b0;
  logic [7:0] io_wdata = 8'h00;
  logic       io_ack;
  logic [7:0] io_rdata;
  logic       uart_rxd = 1'b1;
  logic       uart_txd;
  logic       rx_overrun;
  logic       rx_frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: transmitted frames by start edge, received-byte queue, sticky flags.
  int         fr_start[$];
  logic [7:0] fr_byte[$];
  int         tx_cut = 0;
  int         tx_last_end = 0;
  logic [7:0] rxq[$];
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;
  int         last_push = -1000;
  logic       chk_en = 1'b0;
  int         wr_a = 0;
  int         wr_e = 0;
  int         rd_e = 0;
  bit         rd_had = 1'b0;
  logic       ack_prev = 1'b0;
  logic [7:0] rdata_prev = 8'h00;

  bf_io_uart #(.CLKS_PER_BIT(16'd4), .RX_FIFO_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .io_req(io_req), .io_dir(io_dir), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_txd(input int n);
    logic v;
    int bi;
    logic [7:0] b;
    v = 1'b1;
    for (int i = 0; i < fr_start.size(); i++) begin
      if (n >= fr_start[i] && n < fr_start[i] + FRAME &&
          !(fr_start[i] < tx_cut && n >= tx_cut)) begin
        bi = (n - fr_start[i]) / CPB;
        b  = fr_byte[i];
        if (bi == 0) v = 1'b0;
        else if (bi == 9) v = 1'b1;
        else v = b[bi-1];
      end
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("txd", {31'd0, uart_txd}, {31'd0, exp_txd(cyc)});
      if (io_ack && ack_prev) check("rdata_hold", {24'd0, io_rdata}, {24'd0, rdata_prev});
    end
    ack_prev   <= io_ack;
    rdata_prev <= io_rdata;
  end

  task automatic do_write(input logic [7:0] b);
    int t;
    io_dir = 1'b1; io_wdata = b; io_req = 1'b1;
    wr_e = cyc + 1;
    wr_a = (wr_e + 1 > tx_last_end) ? wr_e + 1 : tx_last_end;
    fr_start.push_back(wr_a);
    fr_byte.push_back(b);
    tx_last_end = wr_a + FRAME;
    t = 0;
    do begin
      tick();
      t++;
      if (t == 1) begin io_wdata = ~b; io_dir = 1'b0; end
    end while (!io_ack && t < 4 * FRAME);
    check("wr_ack_cycle", cyc, wr_a);
    io_req = 1'b0;
    tick();
    check("wr_ack_drop", {31'd0, io_ack}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    for (int bi = 0; bi < 10; bi++) begin
      if (bi == 0) uart_rxd = 1'b0;
      else if (bi == 9) uart_rxd = stop_ok;
      else uart_rxd = b[bi-1];
      for (int c = 0; c < CPB; c++) begin
        if (bi == 9 && c == CPB / 2) begin
          last_push = cyc;
          if (!stop_ok) m_ferr = 1'b1;
          else if (rxq.size() >= DEPTH) m_ovr = 1'b1;
          else rxq.push_back(b);
        end
        tick();
      end
    end
    uart_rxd = 1'b1;
    repeat (2) tick();
  endtask

  task automatic rd_start();
    io_dir = 1'b0; io_req = 1'b1;
    rd_e = cyc + 1;
    rd_had = (rxq.size() > 0) && (cyc - last_push >= 8);
  endtask

  task automatic rd_finish(input int budget, input bit expect_ack);
    int t;
    logic [7:0] exp_b;
    logic [7:0] held;
    t = 0;
    while (!io_ack && t < budget) begin tick(); t++; end
    if (!expect_ack) begin
      check("rd_blocked", {31'd0, io_ack}, 32'd0);
    end else if (!io_ack) begin
      check("rd_ack_timeout", {31'd0, io_ack}, 32'd1);
    end else begin
      if (rxq.size() == 0) begin
        check("rd_model_empty", 32'd0, 32'd1);
        exp_b = 8'h00;
      end else exp_b = rxq.pop_front();
      check("rd_data", {24'd0, io_rdata}, {24'd0, exp_b});
      if (rd_had) check("rd_ack_cycle", cyc, rd_e + 1);
      else check("rd_ack_window",
                 (cyc > last_push && cyc <= last_push + 8 && cyc >= rd_e + 1) ? 32'd1 : 32'd0, 32'd1);
      held = io_rdata;
      repeat (3) tick();
      check("rd_hold", {24'd0, io_rdata}, {24'd0, held});
      io_req = 1'b0;
      tick();
      check("rd_ack_drop", {31'd0, io_ack}, 32'd0);
    end
  endtask

  task automatic do_read();
    rd_start();
    rd_finish(100, 1'b1);
  endtask

  task automatic blocked_then(input logic [7:0] b);
    rd_start();
    rd_finish(60, 1'b0);
    fork
      send_byte(b, 1'b1);
      rd_finish(200, 1'b1);
    join
  endtask

  task automatic check_flags();
    repeat (6) tick();
    check("rx_overrun", {31'd0, rx_overrun}, {31'd0, m_ovr});
    check("rx_frame_err", {31'd0, rx_frame_err}, {31'd0, m_ferr});
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    uart_rxd = 1'b1;
    tx_cut = cyc + 1;
    tx_last_end = 0;
    rxq.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] a5_bits;
    int p;
    a5_bits = 10'b1101001010;
    repeat (3) tick();
    check("rst_txd", {31'd0, uart_txd}, 32'd1);
    check("rst_ack", {31'd0, io_ack}, 32'd0);
    check("rst_rdata", {24'd0, io_rdata}, 32'd0);
    check("rst_ovr", {31'd0, rx_overrun}, 32'd0);
    check("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    repeat (2) tick();

    // Single write, TX idle: ack one cycle after the request is seen, frame bits pinned.
    do_write(8'hA5);
    check("a5_ack_latency", wr_a - wr_e, 32'd1);
    for (int j = 0; j < 10; j++) begin
      while (cyc < wr_a + j * CPB + CPB / 2) tick();
      check("a5_bit", {31'd0, uart_txd}, {31'd0, a5_bits[j]});
    end

    // Back-to-back writes: the second ack waits for the first frame to end.
    do_write(8'h00);
    p = wr_a;
    do_write(8'hFF);
    check("b2b_spacing", wr_a - p, FRAME);
    while (cyc < tx_last_end + 4) tick();

    // Read blocks on empty FIFO until a byte arrives 200 cycles later.
    rd_start();
    fork
      begin repeat (200) tick(); send_byte(8'h3C, 1'b1); end
      rd_finish(600, 1'b1);
    join

    // Overrun: 17 bytes, no reads.
    for (int i = 1; i <= 17; i++) send_byte(i[7:0], 1'b1);
    check_flags();
    check("ovr_set", {31'd0, rx_overrun}, 32'd1);
    for (int i = 0; i < 16; i++) do_read();
    blocked_then(8'h77);

    // Frame error then valid byte; a one-cycle glitch yields nothing.
    send_byte(8'hE7, 1'b0);
    send_byte(8'h55, 1'b1);
    check_flags();
    check("ferr_set", {31'd0, rx_frame_err}, 32'd1);
    do_read();
    uart_rxd = 1'b0;
    tick();
    uart_rxd = 1'b1;
    repeat (3 * CPB) tick();
    blocked_then(8'h66);

    // Reset in the middle of a TX frame and an RX frame.
    send_byte(8'hAB, 1'b1);
    do_write(8'hC3);
    uart_rxd = 1'b0;
    repeat (2 * CPB) tick();
    do_reset(2);
    check("rst2_txd", {31'd0, uart_txd}, 32'd1);
    check("rst2_ack", {31'd0, io_ack}, 32'd0);
    check("rst2_rdata", {24'd0, io_rdata}, 32'd0);
    check("rst2_ovr", {31'd0, rx_overrun}, 32'd0);
    check("rst2_ferr", {31'd0, rx_frame_err}, 32'd0);
    blocked_then(8'h99);
    do_write(8'h5A);
    while (cyc < tx_last_end + 4) tick();

    // Randomized mix of writes (with and without gaps) and receive-then-read.
    for (int it = 0; it < 30; it++) begin
      int r;
      r = $urandom_range(0, 2);
      if (r == 0) do_write(8'($urandom_range(0, 255)));
      else if (r == 1) begin
        repeat ($urandom_range(0, 30)) tick();
        do_write(8'($urandom_range(0, 255)));
      end else begin
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        do_read();
      end
    end
    while (cyc < tx_last_end + 4) tick();
    check_flags();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
